// File: rtl/imsic_msi_router.sv
// MSI router for a set of IMSICs. It decodes bus writes to the machine (M)
// and supervisor/guest (S) interrupt-file windows, keeps a small FIFO of
// pending identities per interrupt file, and counts MSIs lost to full FIFOs.
module imsic_msi_router #(
    parameter int          NR_SRC                = 64,
    parameter int          NR_SRC_LEN            = $clog2(NR_SRC),
    parameter int          NR_IMSICS             = 2,
    parameter int          NR_VS_FILES_PER_IMSIC = 1,
    parameter logic [31:0] IMSIC_M_BASE_ADDR     = 32'h24000000,
    parameter logic [31:0] IMSIC_S_BASE_ADDR     = 32'h28000000,
    parameter int          FIFO_DEPTH            = 4,
    parameter int          ADDR_WIDTH            = 32,
    parameter int          DATA_WIDTH            = 32,
    localparam int         NR_INTP_FILES         = 2 + NR_VS_FILES_PER_IMSIC
) (
    input  logic                                                       i_clk,
    input  logic                                                       ni_rst,
    input  logic                                                       i_en,
    input  logic                                                       i_we,
    input  logic [ADDR_WIDTH-1:0]                                      i_addr,
    input  logic [DATA_WIDTH-1:0]                                      i_wdata,
    output logic                                                       o_rvalid,
    output logic [DATA_WIDTH-1:0]                                      o_rdata,
    output logic                                                       o_err,
    output logic [NR_IMSICS-1:0][NR_INTP_FILES-1:0][NR_SRC_LEN-1:0]    o_setipnum,
    output logic [NR_IMSICS-1:0][NR_INTP_FILES-1:0]                    o_setipnum_valid,
    input  logic [NR_IMSICS-1:0][NR_INTP_FILES-1:0]                    i_setipnum_ready,
    output logic [15:0]                                                o_drop_cnt
);

    localparam int PW         = ADDR_WIDTH - 12;
    localparam int NR_S_PAGES = NR_IMSICS * (NR_INTP_FILES - 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] M_BASE = ADDR_WIDTH'(IMSIC_M_BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] S_BASE = ADDR_WIDTH'(IMSIC_S_BASE_ADDR);

    // ---------------- address decode ----------------
    logic [ADDR_WIDTH-1:0] m_off, s_off;
    logic [PW-1:0]         m_page, s_page;
    logic                  m_hit, s_hit, hit;
    logic [PW-1:0]         tgt_h, tgt_f;
    logic                  sel_le, sel_be;

    assign m_off  = i_addr - M_BASE;
    assign s_off  = i_addr - S_BASE;
    assign m_page = m_off[ADDR_WIDTH-1:12];
    assign s_page = s_off[ADDR_WIDTH-1:12];
    assign m_hit  = (i_addr >= M_BASE) && (m_page < PW'(NR_IMSICS));
    assign s_hit  = (i_addr >= S_BASE) && (s_page < PW'(NR_S_PAGES));
    assign sel_le = (i_addr[11:0] == 12'h000);
    assign sel_be = (i_addr[11:0] == 12'h004);

    // Map the hit page to (IMSIC, file); M pages always hit file 0.
    always_comb begin
        hit   = 1'b0;
        tgt_h = '0;
        tgt_f = '0;
        if (m_hit) begin
            hit   = 1'b1;
            tgt_h = m_page;
        end else if (s_hit) begin
            hit   = 1'b1;
            tgt_h = s_page / PW'(NR_INTP_FILES - 1);
            tgt_f = (s_page % PW'(NR_INTP_FILES - 1)) + PW'(1);
        end
    end

    // ---------------- identity extraction ----------------
    logic [31:0]           wd32, id_word;
    logic [NR_SRC_LEN-1:0] id;
    logic                  id_ok, msi_push;

    assign wd32     = i_wdata[31:0];
    assign id_word  = sel_be ? {wd32[7:0], wd32[15:8], wd32[23:16], wd32[31:24]} : wd32;
    assign id       = id_word[NR_SRC_LEN-1:0];
    // Identity 0 is reserved; any bit above the identity field invalidates the MSI.
    assign id_ok    = ((id_word >> NR_SRC_LEN) == 32'd0) && (id != '0)
                      && (32'(id) < 32'(NR_SRC));
    assign msi_push = i_en && i_we && hit && (sel_le || sel_be) && id_ok;

    // ---------------- bus response ----------------
    logic rvalid_q, err_q;

    // Every access gets a response one cycle later; misses flag an error.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= i_en;
            err_q    <= i_en && !hit;
        end
    end

    assign o_rvalid = rvalid_q;
    assign o_err    = err_q;
    // All readable registers (seteipnum_le/be and reserved) read as zero.
    assign o_rdata  = '0;

    // ---------------- per-file MSI FIFOs ----------------
    logic [NR_IMSICS-1:0][NR_INTP_FILES-1:0] drop_vec;

    for (genvar gi = 0; gi < NR_IMSICS; gi++) begin : g_imsic
        for (genvar gf = 0; gf < NR_INTP_FILES; gf++) begin : g_file
            logic [NR_SRC_LEN-1:0] mem_q [FIFO_DEPTH];
            logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
            logic [CNT_W-1:0]      cnt_q, cnt_d;
            logic                  sel, pop, full, accept;

            assign sel    = msi_push && (tgt_h == PW'(gi)) && (tgt_f == PW'(gf));
            assign pop    = (cnt_q != '0) && i_setipnum_ready[gi][gf];
            assign full   = (cnt_q == CNT_W'(FIFO_DEPTH));
            // A simultaneous pop frees the slot, so a push to a full FIFO still lands.
            assign accept = sel && (!full || pop);
            assign drop_vec[gi][gf] = sel && full && !pop;

            assign wr_ptr_d = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            assign rd_ptr_d = pop    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
            assign cnt_d    = cnt_q + CNT_W'(accept) - CNT_W'(pop);

            // Storage needs no reset: the occupancy count masks stale entries.
            always_ff @(posedge i_clk) begin
                if (accept) begin
                    mem_q[wr_ptr_q] <= id;
                end
            end

            // Pointer and occupancy state, cleared by reset.
            always_ff @(posedge i_clk or negedge ni_rst) begin
                if (!ni_rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    cnt_q    <= cnt_d;
                end
            end

            assign o_setipnum_valid[gi][gf] = (cnt_q != '0);
            assign o_setipnum[gi][gf]       = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
        end
    end

    // ---------------- drop counter ----------------
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign drop_cnt_d = ((|drop_vec) && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1
                                                                 : drop_cnt_q;

    // Saturating count of MSIs lost to full FIFOs.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_cnt = drop_cnt_q;

endmodule
